fft_ctrl: RTL and testbench
===========================

# fft_ctrl

Sequencer for the in-place radix-2 decimation-in-time 64-point FFT datapath. On `start`, it steps through all 6 stages × 32 butterflies. For each butterfly it issues the read addresses of the operand pair and the twiddle index. It replays the addresses as write-backs after the butterfly pipeline latency, and it inserts drain cycles between stages so no stage reads data the previous stage has not yet written. It sits between the top-level start/done handshake and the shared sample RAM, twiddle ROM and butterfly unit.

## Interface
- `N_LOG2`, 6, log2 of FFT length (N = 64); address width = N_LOG2, twiddle index width = N_LOG2-1
- `BFLY_LAT`, 3, butterfly pipeline latency in cycles, read issue to write-back (≥1)
- `clk` in 1, single clock, rising edge
- `rst` in 1, reset, asynchronous, active-high
- `start` in 1, single-cycle request to begin a transform; ignored unless idle
- `busy` out 1, high from the first issue cycle through the last drain cycle
- `done` out 1, one-cycle pulse after the final stage has fully written back
- `rd_en` out 1, butterfly operand read strobe
- `rd_addr_a`, `rd_addr_b` out N_LOG2, operand addresses (b = a + span)
- `tw_idx` out N_LOG2-1, twiddle ROM index, aligned with `rd_en`
- `wr_en` out 1, `rd_en` delayed BFLY_LAT cycles
- `wr_addr_a`, `wr_addr_b` out N_LOG2, read addresses delayed BFLY_LAT cycles
- `stage` out 3, current stage number 0..N_LOG2-1 (debug/scaling)

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE + `start` → ISSUE. Stage counter s=0, butterfly counter j=0.
- ISSUE: `rd_en`=1 every cycle.
  - span h = 1<<s, pos = j & (h-1), grp = j >> s.
  - a = (grp << (s+1)) | pos, b = a + h, tw = pos << (N_LOG2-1-s).
  - j increments. After j = N/2-1, go to DRAIN with a drain counter of BFLY_LAT cycles.
- DRAIN: `rd_en`=0. When the drain counter expires, either go to ISSUE with s+1 and j=0, or, if s = N_LOG2-1, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` in any state other than IDLE is ignored. A transform is never restarted mid-run.
- Write-back path: a BFLY_LAT-deep shift register carries {`rd_en`, a, b}. It runs independently of the FSM, so writes from the last issue cycles still complete during DRAIN.
- All counters are unsigned and wrap-free. j and s saturate at their terminal values; no overflow is possible.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wr_en` = 0; all addresses, `tw_idx` and `stage` = 0; FSM = IDLE; shift register cleared.
- `start` sampled high at edge T → first `rd_en` and `busy` at cycle T+1.
- Each stage = N/2 issue cycles + BFLY_LAT drain cycles.
- With defaults: 6 × 35 = 210 busy cycles; `done` high at cycle T+211; `busy` low in the `done` cycle.
- Last write of stage s occurs in the final DRAIN cycle. The first read of stage s+1 occurs in the next cycle, so the RAM must provide write-then-read ordering across adjacent cycles.
- `start` coincident with `done`: ignored (FSM not yet IDLE). `start` accepted in the cycle after `done`.
- `rst` mid-transform: all state and the shift register clear immediately. No stale `wr_en` follows reset.

## Configuration
- `FFT_CTRL_IFFT_EN` defined:
  - adds input `inverse` (1 bit), sampled only at the cycle `start` is accepted;
  - adds output `tw_conj` (1 bit), equal to the latched value and held through the transform;
  - the butterfly conjugates the twiddle when `tw_conj`=1;
  - `tw_conj` resets to 0.
- Undefined: neither port exists; the transform is always forward.

## Structure
- Shared package `fft_pkg`: N_LOG2/N constants, the `addr_t` and `tw_idx_t` typedefs, and the state enum `fft_ctrl_state_e` (also reused by the top-level FFT).
- One sub-module, `fft_ctrl_delay`: a parameterised-width, BFLY_LAT-deep register delay line with async clear, used for the write-back path.

## Test plan
- Reset then idle → all outputs 0 for 20 cycles; `start` during `rst` is ignored.
- `start` at T → stage 0, j=0: a=0, b=1, tw=0 at T+1; stage 0, j=5: a=10, b=11, tw=0.
- Stage 2, j=5 → a=9, b=13, tw=8. Stage 5, j=5 → a=5, b=37, tw=5. Every stage touches each address 0..63 exactly once.
- Default parameters → `done` at T+211. `wr_en` equals `rd_en` delayed 3 cycles with matching addresses. There are 3 idle `rd_en` cycles between stages.
- `start` pulses at T+50 and at the `done` cycle → ignored. `start` one cycle after `done` → new run with first read the next cycle.
- `rst` asserted at T+100 → `wr_en`, `busy` = 0 immediately and stay 0. With `FFT_CTRL_IFFT_EN`, `inverse`=1 at `start` → `tw_conj`=1 through the run and 0 after reset.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, address/twiddle types, controller state enum and butterfly address helpers.
package fft_pkg;

    localparam int N_LOG2 = 6;
    localparam int N      = 1 << N_LOG2;

    typedef logic [N_LOG2-1:0] addr_t;
    typedef logic [N_LOG2-2:0] tw_idx_t;
    typedef logic [2:0]        stage_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fft_ctrl_state_e;

    // Lower operand of butterfly j in stage s: the group index skips over the upper half-block.
    function automatic addr_t bfly_base(stage_t s, tw_idx_t j);
        addr_t jj   = addr_t'(j);
        addr_t mask = (addr_t'(1) << s) - addr_t'(1);
        return ((jj >> s) << (s + 3'd1)) | (jj & mask);
    endfunction

    function automatic tw_idx_t bfly_tw(stage_t s, tw_idx_t j);
        addr_t jj   = addr_t'(j);
        addr_t mask = (addr_t'(1) << s) - addr_t'(1);
        return tw_idx_t'((jj & mask) << (stage_t'(N_LOG2 - 1) - s));
    endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// fft_ctrl_if: start/done handshake plus RAM, twiddle ROM and butterfly control bus.
// FFT_CTRL_IFFT_EN adds the inverse request and the twiddle-conjugate flag.
interface fft_ctrl_if;
    import fft_pkg::*;

    logic    start;
    logic    busy;
    logic    done;
    logic    rd_en;
    addr_t   rd_addr_a;
    addr_t   rd_addr_b;
    tw_idx_t tw_idx;
    logic    wr_en;
    addr_t   wr_addr_a;
    addr_t   wr_addr_b;
    stage_t  stage;
`ifdef FFT_CTRL_IFFT_EN
    logic    inverse;
    logic    tw_conj;
`endif

    modport master (
        input  start,
`ifdef FFT_CTRL_IFFT_EN
        input  inverse,
        output tw_conj,
`endif
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
        output wr_en, wr_addr_a, wr_addr_b, stage
    );

    modport slave (
        output start,
`ifdef FFT_CTRL_IFFT_EN
        output inverse,
        input  tw_conj,
`endif
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
        input  wr_en, wr_addr_a, wr_addr_b, stage
    );

endinterface

// File: rtl/fft_ctrl_delay.sv
// fft_ctrl_delay: DEPTH-stage register delay line with asynchronous clear.
module fft_ctrl_delay #(
    parameter int W     = 13,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: in-place radix-2 DIT FFT sequencer (stages x butterflies, write-back replay, inter-stage drain).
// Define FFT_CTRL_IFFT_EN to latch an inverse request into tw_conj at start.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int BFLY_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    fft_ctrl_if.master bus
);

    localparam int CW = $clog2(BFLY_LAT + 1);
    localparam int WW = 1 + 2 * N_LOG2;

    fft_ctrl_state_e state, state_n;
    stage_t          s, s_n;
    tw_idx_t         j, j_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            rd;
    addr_t           a, b;
    logic [WW-1:0]   wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            j     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            s     <= s_n;
            j     <= j_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        j_n     = j;
        cnt_n   = cnt;
        unique case (state)
            IDLE: if (bus.start) begin
                state_n = ISSUE;
                s_n     = '0;
                j_n     = '0;
            end
            ISSUE: if (j == tw_idx_t'(N / 2 - 1)) begin
                state_n = DRAIN;
                cnt_n   = CW'(BFLY_LAT - 1);
            end else begin
                j_n = j + 1'b1;
            end
            // Drain lets the last butterflies of this stage write back before the next stage reads.
            DRAIN: if (cnt != '0) begin
                cnt_n = cnt - 1'b1;
            end else if (s == stage_t'(N_LOG2 - 1)) begin
                state_n = DONE;
            end else begin
                state_n = ISSUE;
                s_n     = s + 1'b1;
                j_n     = '0;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign rd = state == ISSUE;
    assign a  = rd ? bfly_base(s, j) : '0;
    assign b  = rd ? a + (addr_t'(1) << s) : '0;

    assign bus.rd_en     = rd;
    assign bus.rd_addr_a = a;
    assign bus.rd_addr_b = b;
    assign bus.tw_idx    = rd ? bfly_tw(s, j) : '0;
    assign bus.busy      = state == ISSUE || state == DRAIN;
    assign bus.done      = state == DONE;
    assign bus.stage     = s;

    fft_ctrl_delay #(.W(WW), .DEPTH(BFLY_LAT)) u_wb (
        .clk (clk),
        .rst (rst),
        .d   ({rd, a, b}),
        .q   (wb)
    );

    assign {bus.wr_en, bus.wr_addr_a, bus.wr_addr_b} = wb;

`ifdef FFT_CTRL_IFFT_EN
    logic conj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) conj <= 1'b0;
        else if (state == IDLE && bus.start) conj <= bus.inverse;
    end

    assign bus.tw_conj = conj;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: directed bench for fft_ctrl with a per-cycle schedule model and hand-computed address vectors.
module tb_fft_ctrl;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   hits [64];
    int   gap = 0;

    fft_ctrl_if bus();

    fft_ctrl #(.BFLY_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b,
                    bus.tw_idx, bus.wr_addr_a, bus.wr_addr_b, bus.stage});
    endfunction

    // Expected schedule: cycle rel=1 is the first issue; each stage is 32 issue + 3 drain cycles.
    task automatic cycle(input int rel);
        logic busy_e, rd_e, wr_e;
        int   s, j, h, ea, rw, sw, jw, hw, ew, bad;
        busy_e = rel >= 1 && rel <= 210;
        rd_e   = busy_e && ((rel - 1) % 35) < 32;
        rw     = rel - 3;
        wr_e   = rw >= 1 && rw <= 210 && ((rw - 1) % 35) < 32;
        check("busy", 64'(bus.busy), 64'(busy_e));
        check("done", 64'(bus.done), 64'(rel == 211));
        check("rd_en", 64'(bus.rd_en), 64'(rd_e));
        check("wr_en", 64'(bus.wr_en), 64'(wr_e));
        if (busy_e) check("stage", 64'(bus.stage), 64'((rel - 1) / 35));
        if (rd_e) begin
            s  = (rel - 1) / 35;
            j  = (rel - 1) % 35;
            h  = 1 << s;
            ea = (j / h) * (2 * h) + j % h;
            check("rd_a", 64'(bus.rd_addr_a), 64'(ea));
            check("rd_b", 64'(bus.rd_addr_b), 64'(ea + h));
            check("tw", 64'(bus.tw_idx), 64'((j % h) * (32 / h)));
            hits[bus.rd_addr_a]++;
            hits[bus.rd_addr_b]++;
            if (j == 31) begin
                bad = 0;
                foreach (hits[i]) begin
                    if (hits[i] != 1) bad++;
                    hits[i] = 0;
                end
                check("cover", 64'(bad), 64'(0));
            end
        end
        if (wr_e) begin
            sw = (rw - 1) / 35;
            jw = (rw - 1) % 35;
            hw = 1 << sw;
            ew = (jw / hw) * (2 * hw) + jw % hw;
            check("wr_a", 64'(bus.wr_addr_a), 64'(ew));
            check("wr_b", 64'(bus.wr_addr_b), 64'(ew + hw));
        end
    endtask

    initial begin
        bus.start = 1'b1;
`ifdef FFT_CTRL_IFFT_EN
        bus.inverse = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_outs", outs(), 64'(0));
        rst       = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", outs(), 64'(0));
        end
        bus.start = 1'b1;
        for (int c = 1; c <= 212; c++) begin
            @(negedge clk);
            cycle(c);
            case (c)
                1: begin
                    check("s0j0_a", 64'(bus.rd_addr_a), 64'(0));
                    check("s0j0_b", 64'(bus.rd_addr_b), 64'(1));
                    check("s0j0_tw", 64'(bus.tw_idx), 64'(0));
                end
                6: begin
                    check("s0j5_a", 64'(bus.rd_addr_a), 64'(10));
                    check("s0j5_b", 64'(bus.rd_addr_b), 64'(11));
                    check("s0j5_tw", 64'(bus.tw_idx), 64'(0));
                end
                76: begin
                    check("s2j5_a", 64'(bus.rd_addr_a), 64'(9));
                    check("s2j5_b", 64'(bus.rd_addr_b), 64'(13));
                    check("s2j5_tw", 64'(bus.tw_idx), 64'(8));
                end
                181: begin
                    check("s5j5_a", 64'(bus.rd_addr_a), 64'(5));
                    check("s5j5_b", 64'(bus.rd_addr_b), 64'(37));
                    check("s5j5_tw", 64'(bus.tw_idx), 64'(5));
                end
                211: check("done_t211", 64'(bus.done), 64'(1));
                default: ;
            endcase
            if (c >= 33 && c <= 35 && !bus.rd_en) gap++;
            if (c == 36) check("gap", 64'(gap), 64'(3));
`ifdef FFT_CTRL_IFFT_EN
            if (c == 100) check("conj_fwd", 64'(bus.tw_conj), 64'(0));
            bus.inverse = c == 212;
`endif
            bus.start = c == 50 || c == 211 || c == 212;
        end
        for (int c = 213; c <= 312; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            cycle(c - 212);
            if (c == 213) check("restart_rd", 64'(bus.rd_en), 64'(1));
`ifdef FFT_CTRL_IFFT_EN
            bus.inverse = 1'b0;
            if (c == 300) check("conj_inv", 64'(bus.tw_conj), 64'(1));
`endif
        end
        rst = 1'b1;
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_wr_en", 64'(bus.wr_en), 64'(0));
        check("rst_rd_en", 64'(bus.rd_en), 64'(0));
`ifdef FFT_CTRL_IFFT_EN
        check("rst_conj", 64'(bus.tw_conj), 64'(0));
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst", outs(), 64'(0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
